// File: rtl/axis_s2mm_framer.sv
// Pairs real/imag AXI-Stream beats into fixed-length frames for a pair of DMA S2MM channels.
// Optional macro FRAMER_DROP_CNT_EN adds a saturating drop_count output.
module axis_s2mm_framer #(
  parameter int unsigned SDATA_WIDTH = 128,
  parameter int unsigned FRAME_BEATS = 256,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     s_axis_real_tvalid,
  output logic                     s_axis_real_tready,
  input  logic [SDATA_WIDTH-1:0]   s_axis_real_tdata,
  input  logic                     s_axis_imag_tvalid,
  output logic                     s_axis_imag_tready,
  input  logic [SDATA_WIDTH-1:0]   s_axis_imag_tdata,
  output logic [SDATA_WIDTH-1:0]   m_axis_real_s2mm_tdata,
  output logic [SDATA_WIDTH/8-1:0] m_axis_real_s2mm_tkeep,
  output logic                     m_axis_real_s2mm_tlast,
  output logic                     m_axis_real_s2mm_tvalid,
  input  logic                     m_axis_real_s2mm_tready,
  output logic [SDATA_WIDTH-1:0]   m_axis_imag_s2mm_tdata,
  output logic [SDATA_WIDTH/8-1:0] m_axis_imag_s2mm_tkeep,
  output logic                     m_axis_imag_s2mm_tlast,
  output logic                     m_axis_imag_s2mm_tvalid,
  input  logic                     m_axis_imag_s2mm_tready,
  output logic [31:0]              frame_count,
  output logic                     overflow,
  output logic                     pair_error
`ifdef FRAMER_DROP_CNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int unsigned KW = SDATA_WIDTH / 8;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FRAME_BEATS);
  localparam int unsigned EW = 2 * SDATA_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic                   ready_en;
  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            mem_cnt;
  logic [AW:0]            occ;
  logic [CW-1:0]          beat_cnt;
  logic [CW-1:0]          beat_cnt_nxt;
  logic                   out_valid;
  logic                   out_last;
  logic [SDATA_WIDTH-1:0] out_real;
  logic [SDATA_WIDTH-1:0] out_imag;

  logic m_pop;
  logic s_ready;
  logic both_valid;
  logic capture;
  logic push;
  logic drop;
  logic load;
  logic beat_last;

  // Occupancy counts the output register too, so the whole pipe holds FIFO_DEPTH pairs.
  always_comb begin
    m_pop      = out_valid & m_axis_real_s2mm_tready & m_axis_imag_s2mm_tready;
    occ        = mem_cnt + (AW+1)'(out_valid);
    s_ready    = ready_en & ((state == ST_IDLE) | (occ != (AW+1)'(FIFO_DEPTH)) | m_pop);
    both_valid = s_axis_real_tvalid & s_axis_imag_tvalid;
    capture    = (state != ST_IDLE);
    push       = both_valid & s_ready & capture;
    drop       = both_valid & ~s_ready & capture;
    load       = (mem_cnt != '0) & (~out_valid | m_pop);
    beat_last  = (beat_cnt == CW'(FRAME_BEATS - 1));
    beat_cnt_nxt = beat_cnt;
    if (push) begin
      beat_cnt_nxt = beat_last ? '0 : beat_cnt + CW'(1);
    end
  end

  assign s_axis_real_tready = s_ready;
  assign s_axis_imag_tready = s_ready;

  // Leaving RUN on a frame boundary needs no drain.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_RUN;
      ST_RUN:   if (!enable) state_nxt = (beat_cnt_nxt == '0) ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (push && beat_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {beat_last, s_axis_imag_tdata, s_axis_real_tdata};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ready_en    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      beat_cnt    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      pair_error  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      beat_cnt <= beat_cnt_nxt;
      mem_cnt  <= mem_cnt + (AW+1)'(push) - (AW+1)'(load);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_valid <= 1'b1;
        out_last  <= mem[rd_ptr][EW-1];
        out_imag  <= mem[rd_ptr][2*SDATA_WIDTH-1:SDATA_WIDTH];
        out_real  <= mem[rd_ptr][SDATA_WIDTH-1:0];
      end else if (m_pop) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (m_pop && out_last) begin
        frame_count <= frame_count + 32'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (s_axis_real_tvalid ^ s_axis_imag_tvalid) begin
        pair_error <= 1'b1;
      end
    end
  end

`ifdef FRAMER_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

  assign m_axis_real_s2mm_tdata  = out_real;
  assign m_axis_imag_s2mm_tdata  = out_imag;
  assign m_axis_real_s2mm_tlast  = out_last;
  assign m_axis_imag_s2mm_tlast  = out_last;
  assign m_axis_real_s2mm_tvalid = out_valid;
  assign m_axis_imag_s2mm_tvalid = out_valid;
  assign m_axis_real_s2mm_tkeep  = {KW{out_valid}};
  assign m_axis_imag_s2mm_tkeep  = {KW{out_valid}};

endmodule

// File: tb/tb_axis_s2mm_framer.sv
// Bench for axis_s2mm_framer: transaction-level queue model checked every cycle plus literal scenario checks.
module tb_axis_s2mm_framer;

  localparam int SW = 32;
  localparam int FB = 4;
  localparam int FD = 16;
  localparam int KW = SW / 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          s_axis_real_tvalid = 1'b0;
  logic          s_axis_real_tready;
  logic [SW-1:0] s_axis_real_tdata = '0;
  logic          s_axis_imag_tvalid = 1'b0;
  logic          s_axis_imag_tready;
  logic [SW-1:0] s_axis_imag_tdata = '0;
  logic [SW-1:0] m_axis_real_s2mm_tdata;
  logic [KW-1:0] m_axis_real_s2mm_tkeep;
  logic          m_axis_real_s2mm_tlast;
  logic          m_axis_real_s2mm_tvalid;
  logic          m_axis_real_s2mm_tready = 1'b1;
  logic [SW-1:0] m_axis_imag_s2mm_tdata;
  logic [KW-1:0] m_axis_imag_s2mm_tkeep;
  logic          m_axis_imag_s2mm_tlast;
  logic          m_axis_imag_s2mm_tvalid;
  logic          m_axis_imag_s2mm_tready = 1'b1;
  logic [31:0]   frame_count;
  logic          overflow;
  logic          pair_error;
`ifdef FRAMER_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  always #5 clock = ~clock;

  axis_s2mm_framer #(.SDATA_WIDTH(SW), .FRAME_BEATS(FB), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .s_axis_real_tvalid(s_axis_real_tvalid), .s_axis_real_tready(s_axis_real_tready),
    .s_axis_real_tdata(s_axis_real_tdata),
    .s_axis_imag_tvalid(s_axis_imag_tvalid), .s_axis_imag_tready(s_axis_imag_tready),
    .s_axis_imag_tdata(s_axis_imag_tdata),
    .m_axis_real_s2mm_tdata(m_axis_real_s2mm_tdata), .m_axis_real_s2mm_tkeep(m_axis_real_s2mm_tkeep),
    .m_axis_real_s2mm_tlast(m_axis_real_s2mm_tlast), .m_axis_real_s2mm_tvalid(m_axis_real_s2mm_tvalid),
    .m_axis_real_s2mm_tready(m_axis_real_s2mm_tready),
    .m_axis_imag_s2mm_tdata(m_axis_imag_s2mm_tdata), .m_axis_imag_s2mm_tkeep(m_axis_imag_s2mm_tkeep),
    .m_axis_imag_s2mm_tlast(m_axis_imag_s2mm_tlast), .m_axis_imag_s2mm_tvalid(m_axis_imag_s2mm_tvalid),
    .m_axis_imag_s2mm_tready(m_axis_imag_s2mm_tready),
    .frame_count(frame_count), .overflow(overflow), .pair_error(pair_error)
`ifdef FRAMER_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: every accepted pair is queued; it becomes visible two cycles after acceptance
  // once it reaches the queue head, and occupancy is simply the queue length.
  typedef struct {
    logic [SW-1:0] r;
    logic [SW-1:0] i;
    logic          last;
    int            acc;
  } beat_t;

  beat_t       q[$];
  int          cyc = 0;
  int          st = 0;
  int          cnt = 0;
  logic [31:0] e_frames = '0;
  logic        e_ovf = 1'b0;
  logic        e_perr = 1'b0;
  int          e_drops = 0;
  logic        e_ren = 1'b0;
  bit          live = 1'b0;
  int          out_beats = 0;
  logic [31:0] last_mask = '0;

  always @(negedge clock) begin : cmp_model
    logic  ev, epop, erdy, lastw;
    beat_t b;
    ev   = (q.size() > 0) && (cyc >= q[0].acc + 2);
    epop = ev && m_axis_real_s2mm_tready && m_axis_imag_s2mm_tready;
    erdy = e_ren && (st == 0 || q.size() < FD || epop);
    if (live) begin
      check("tvalid_real", 64'(m_axis_real_s2mm_tvalid), 64'(ev));
      check("tvalid_imag", 64'(m_axis_imag_s2mm_tvalid), 64'(ev));
      check("tkeep_real", 64'(m_axis_real_s2mm_tkeep), 64'({KW{ev}}));
      check("tkeep_imag", 64'(m_axis_imag_s2mm_tkeep), 64'({KW{ev}}));
      if (ev) begin
        check("tdata_real", 64'(m_axis_real_s2mm_tdata), 64'(q[0].r));
        check("tdata_imag", 64'(m_axis_imag_s2mm_tdata), 64'(q[0].i));
        check("tlast_real", 64'(m_axis_real_s2mm_tlast), 64'(q[0].last));
        check("tlast_imag", 64'(m_axis_imag_s2mm_tlast), 64'(q[0].last));
      end
      check("s_tready_real", 64'(s_axis_real_tready), 64'(erdy));
      check("s_tready_imag", 64'(s_axis_imag_tready), 64'(erdy));
      check("frame_count", 64'(frame_count), 64'(e_frames));
      check("overflow", 64'(overflow), 64'(e_ovf));
      check("pair_error", 64'(pair_error), 64'(e_perr));
`ifdef FRAMER_DROP_CNT_EN
      check("drop_count", 64'(drop_count), 64'(e_drops));
`endif
      if (m_axis_real_s2mm_tvalid && m_axis_real_s2mm_tready && m_axis_imag_s2mm_tready) begin
        out_beats++;
        if (m_axis_real_s2mm_tlast && out_beats <= 32) last_mask[out_beats-1] = 1'b1;
      end
    end
    if (!resetn) begin
      q.delete();
      st = 0; cnt = 0; e_frames = '0; e_ovf = 1'b0; e_perr = 1'b0; e_drops = 0;
      e_ren = 1'b0; live = 1'b1;
    end else begin
      e_ren = 1'b1;
      lastw = 1'b0;
      if (epop) begin
        b = q.pop_front();
        if (b.last) e_frames = e_frames + 32'd1;
      end
      if (s_axis_real_tvalid ^ s_axis_imag_tvalid) e_perr = 1'b1;
      if (s_axis_real_tvalid && s_axis_imag_tvalid && st != 0) begin
        if (erdy) begin
          b.r = s_axis_real_tdata;
          b.i = s_axis_imag_tdata;
          b.last = (cnt == FB - 1);
          b.acc = cyc;
          q.push_back(b);
          lastw = b.last;
          cnt = (cnt + 1) % FB;
        end else begin
          e_ovf = 1'b1;
          if (e_drops < 65535) e_drops++;
        end
      end
      case (st)
        0: if (enable) st = 1;
        1: if (!enable) st = (cnt == 0) ? 0 : 2;
        2: if (lastw) st = 0;
        default: st = 0;
      endcase
    end
    cyc++;
  end

  logic [15:0] seq = '0;

  task automatic drive(input logic rv, input logic iv);
    @(posedge clock);
    #1;
    s_axis_real_tvalid = rv;
    s_axis_imag_tvalid = iv;
    s_axis_real_tdata  = {16'hA5C0, seq};
    s_axis_imag_tdata  = {~seq, seq ^ 16'h3C3C};
    if (rv || iv) seq = seq + 16'd1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0);
  endtask

  logic vs[8];

  initial begin
    // Reset state
    @(negedge clock);
    check("rst_tvalid", 64'(m_axis_real_s2mm_tvalid), 64'd0);
    check("rst_tready", 64'(s_axis_real_tready), 64'd0);
    check("rst_frames", 64'(frame_count), 64'd0);
    drive(1'b0, 1'b0);
    resetn = 1'b1;
    enable = 1'b1;

    // Eight continuous pairs, two frames of four
    out_beats = 0; last_mask = '0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1);
      @(negedge clock);
      vs[k] = m_axis_real_s2mm_tvalid;
    end
    check("lat_c0", 64'(vs[0]), 64'd0);
    check("lat_c1", 64'(vs[1]), 64'd0);
    check("lat_c2", 64'(vs[2]), 64'd1);
    idle(6);
    @(negedge clock);
    check("a_frames", 64'(frame_count), 64'd2);
    check("a_beats", 64'(out_beats), 64'd8);
    check("a_tlast_pos", 64'(last_mask), 64'h88);

    // Enable dropped mid-frame: frame completes, then pairs are discarded
    out_beats = 0; last_mask = '0;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    enable = 1'b0;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    @(negedge clock);
    check("b_idle_tready", 64'(s_axis_real_tready), 64'd1);
    idle(6);
    @(negedge clock);
    check("b_frames", 64'(frame_count), 64'd3);
    check("b_beats", 64'(out_beats), 64'd4);
    check("b_tlast_pos", 64'(last_mask), 64'h08);
    check("b_no_ovf", 64'(overflow), 64'd0);

    // Imag sink stalled: 16 stored, 4 dropped, then everything drains
    out_beats = 0;
    m_axis_imag_s2mm_tready = 1'b0;
    enable = 1'b1;
    drive(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    m_axis_imag_s2mm_tready = 1'b1;
    @(negedge clock);
    check("c_overflow", 64'(overflow), 64'd1);
`ifdef FRAMER_DROP_CNT_EN
    check("c_drop_count", 64'(drop_count), 64'd4);
`endif
    idle(22);
    @(negedge clock);
    check("c_beats", 64'(out_beats), 64'd16);
    check("c_frames", 64'(frame_count), 64'd7);

    // One-cycle reset with three beats queued
    m_axis_real_s2mm_tready = 1'b0;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    resetn = 1'b0;
    drive(1'b0, 1'b0);
    resetn = 1'b1;
    @(negedge clock);
    check("e_tvalid", 64'(m_axis_real_s2mm_tvalid | m_axis_imag_s2mm_tvalid), 64'd0);
    check("e_tready", 64'(s_axis_real_tready | s_axis_imag_tready), 64'd0);
    check("e_tkeep", 64'({m_axis_real_s2mm_tkeep, m_axis_imag_s2mm_tkeep}), 64'd0);
    check("e_tlast", 64'(m_axis_real_s2mm_tlast | m_axis_imag_s2mm_tlast), 64'd0);
    check("e_tdata", 64'({m_axis_real_s2mm_tdata, m_axis_imag_s2mm_tdata}), 64'd0);
    check("e_frames", 64'(frame_count), 64'd0);
    check("e_flags", 64'({overflow, pair_error}), 64'd0);
    m_axis_real_s2mm_tready = 1'b1;
    idle(4);
    @(negedge clock);
    check("e_empty", 64'(m_axis_real_s2mm_tvalid), 64'd0);

    // Full FIFO with simultaneous pop and push
    out_beats = 0;
    m_axis_real_s2mm_tready = 1'b0;
    m_axis_imag_s2mm_tready = 1'b0;
    for (int k = 0; k < 16; k++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    @(negedge clock);
    check("d_full_tready", 64'(s_axis_real_tready), 64'd0);
    drive(1'b1, 1'b1);
    m_axis_real_s2mm_tready = 1'b1;
    m_axis_imag_s2mm_tready = 1'b1;
    @(negedge clock);
    check("d_popush_tready", 64'(s_axis_real_tready), 64'd1);
    drive(1'b0, 1'b0);
    m_axis_real_s2mm_tready = 1'b0;
    m_axis_imag_s2mm_tready = 1'b0;
    @(negedge clock);
    check("d_still_full", 64'(s_axis_imag_tready), 64'd0);
    check("d_no_ovf", 64'(overflow), 64'd0);
    m_axis_real_s2mm_tready = 1'b1;
    m_axis_imag_s2mm_tready = 1'b1;
    idle(20);
    @(negedge clock);
    check("d_beats", 64'(out_beats), 64'd17);
    check("d_frames", 64'(frame_count), 64'd4);

    // Unpaired real beat: flagged, not written, counter untouched
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    @(negedge clock);
    check("f_pair_error", 64'(pair_error), 64'd1);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1);
    idle(6);
    @(negedge clock);
    check("f_frames", 64'(frame_count), 64'd5);
    check("f_beats", 64'(out_beats), 64'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
